// File: rtl/mem_pkg.sv
// Shared memory-subsystem definitions used by mem_map, sdram_ctl and dram_arbiter.
package mem_pkg;

    localparam int unsigned DRAM_ADDR_W = 25;
    localparam int unsigned DRAM_DATA_W = 16;
    localparam int unsigned WD_W        = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StAbort
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after i_last, wrapping.
module rr_pick #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned IDX_W     = 2
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last,
    output logic [IDX_W-1:0]     o_sel,
    output logic                 o_any
);

    int unsigned      w_idx;
    logic [IDX_W-1:0] w_k;

    always_comb begin
        o_any = 1'b0;
        o_sel = '0;
        w_idx = 0;
        w_k   = '0;
        // Offset 1 first so the previous owner is considered last.
        for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
            w_idx = (int'(i_last) + i) % NUM_PORTS;
            w_k   = IDX_W'(w_idx);
            if (!o_any && i_req[w_k]) begin
                o_any = 1'b1;
                o_sel = w_k;
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one sdram_ctl port among NUM_PORTS requesters,
// one transaction at a time, with a watchdog that aborts stalled transactions.
module dram_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0]             req_we,
    input  logic [NUM_PORTS*DRAM_ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DRAM_DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]             gnt,
    output logic [NUM_PORTS-1:0]             done,
    output logic [NUM_PORTS-1:0]             err,
    output logic [DRAM_DATA_W-1:0]           rdata,
    output logic [DRAM_ADDR_W-1:0]           dram_addr,
    output logic                             dram_write_en,
    output logic [DRAM_DATA_W-1:0]           dram_data_in,
    output logic                             dram_refresh_data,
    input  logic [DRAM_DATA_W-1:0]           dram_read_data,
    input  logic                             dram_data_ready
);

    localparam int unsigned      IDX_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_PORTS - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [IDX_W-1:0]       r_sel;
    logic [IDX_W-1:0]       r_last;
    logic [WD_W-1:0]        r_wd;
    logic [DRAM_DATA_W-1:0] r_rdata;
    logic [DRAM_ADDR_W-1:0] r_addr;
    logic                   r_we;
    logic [DRAM_DATA_W-1:0] r_wdata;

    logic [IDX_W-1:0]       w_sel;
    logic                   w_any;
    logic [NUM_PORTS-1:0]   w_sel_oh;
    logic [DRAM_ADDR_W-1:0] w_addr  [NUM_PORTS];
    logic [DRAM_DATA_W-1:0] w_wdata [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr[g]  = req_addr[g*DRAM_ADDR_W +: DRAM_ADDR_W];
        assign w_wdata[g] = req_wdata[g*DRAM_DATA_W +: DRAM_DATA_W];
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_rr_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_sel  (w_sel),
        .o_any  (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_any) w_state_next = StIssue;
            StIssue: w_state_next = StWait;
            StWait: begin
                // A completion in the final watchdog cycle still counts as success.
                if (dram_data_ready)      w_state_next = StDone;
                else if (r_wd == WD_LAST) w_state_next = StAbort;
            end
            StDone:  w_state_next = StIdle;
            StAbort: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_sel   <= '0;
            r_last  <= LAST_RST;
            r_wd    <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            unique case (r_state)
                StIdle: begin
                    if (w_any) begin
                        r_sel   <= w_sel;
                        r_addr  <= w_addr[w_sel];
                        r_we    <= req_we[w_sel];
                        r_wdata <= w_wdata[w_sel];
                    end
                end
                StIssue: r_wd <= '0;
                StWait: begin
                    if (dram_data_ready) begin
                        r_rdata <= dram_read_data;
                        r_last  <= r_sel;
                    end else if (r_wd == WD_LAST) begin
                        r_last <= r_sel;
                    end
                    if (r_wd != '1) r_wd <= r_wd + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_sel_oh = NUM_PORTS'(1) << r_sel;

    assign gnt               = (r_state != StIdle) ? w_sel_oh : '0;
    assign done              = (r_state == StDone) ? w_sel_oh : '0;
    assign err               = (r_state == StAbort) ? w_sel_oh : '0;
    assign dram_refresh_data = (r_state == StIssue);
    assign rdata             = r_rdata;
    assign dram_addr         = r_addr;
    assign dram_write_en     = r_we;
    assign dram_data_in      = r_wdata;

endmodule
